// File: rtl/cnn_accel_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cnn_accel_pkg
//  Description : Shared encodings for the CNN accelerator datapath blocks:
//                upsampler FSM state codes, upsample mode codes and the
//                2x2 block packing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_accel_pkg;

  // Upsampler control FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_WAIT_WR = 2'd3;

  // Upsample mode encoding
  localparam logic MODE_NEAREST = 1'b0;  // replicate pixel into all four
  localparam logic MODE_ZERO    = 1'b1;  // pixel top-left, zeros elsewhere

  // Pack one source pixel into a 2x2 output block.
  // Byte order: [7:0] top-left, [15:8] top-right,
  //             [23:16] bottom-left, [31:24] bottom-right.
  function automatic logic [31:0] pack_block(input logic m, input logic [7:0] p);
    if (m == MODE_ZERO) begin
      return {8'h00, 8'h00, 8'h00, p};
    end
    return {p, p, p, p};
  endfunction

endpackage : cnn_accel_pkg
`default_nettype wire

// File: rtl/raster_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : raster_addr_gen
//  Description : Raster-order row/col counter with a linear address that
//                tracks row*WIDTH+col without a multiplier. Advances on
//                en_i, wraps col at WIDTH-1 and the whole frame after the
//                last pixel; last_o flags the final pixel of the frame.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk     in   clock, rising edge
//    rstn    in   asynchronous active-low reset
//    clr_i   in   synchronous restart at address 0 (priority over en_i)
//    en_i    in   advance to the next raster position
//    addr_o  out  current linear address
//    last_o  out  current position is (HEIGHT-1, WIDTH-1)
// ============================================================================
module raster_addr_gen #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [COL_W-1:0]  col_q,  col_d;
  logic [ROW_W-1:0]  row_q,  row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              col_end, row_end;

  assign col_end = (col_q == COL_W'(WIDTH - 1));
  assign row_end = (row_q == ROW_W'(HEIGHT - 1));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clr_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (en_i) begin
      if (col_end) begin
        col_d = '0;
        if (row_end) begin
          // Frame wrap: leaves the counter ready for the next frame
          row_d  = '0;
          addr_d = '0;
        end else begin
          row_d  = row_q + ROW_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end else begin
        col_d  = col_q + COL_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = col_end & row_end;

endmodule : raster_addr_gen
`default_nettype wire

// File: rtl/upsample_2x_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : upsample_2x_ctrl
//  Description : 2x upsampling controller. Reads a WIDTH x HEIGHT 8-bit
//                source map in raster order and emits one packed 2x2 block
//                per source pixel to the 2x BMP writer, then waits for the
//                writer's frame_done rising edge before completing.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk            in   clock, rising edge
//    rstn           in   asynchronous active-low reset
//    start          in   frame start pulse (accepted only in IDLE)
//    mode           in   0 nearest replicate, 1 zero-insert (latched on start)
//    hold           in   pause new source reads
//    mem_rd_en      out  source buffer read strobe
//    mem_addr       out  source buffer address
//    mem_rdata      in   source pixel, valid the cycle after mem_rd_en
//    out_data       out  packed 2x2 block (WI bits, WI = 32 only)
//    out_vld        out  out_data valid
//    frame_done_in  in   writer frame_done level
//    busy           out  frame in progress
//    done           out  one-cycle completion pulse
// ============================================================================
module upsample_2x_ctrl
  import cnn_accel_pkg::*;
#(
  parameter int WI     = 32,
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              mode,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [WI-1:0]     out_data,
  output logic              out_vld,
  input  logic              frame_done_in,
  output logic              busy,
  output logic              done
);

  logic [1:0]    state_q, state_d;
  logic          mode_q;
  logic          rd_pend_q;     // read issued last cycle, data arrives now
  logic          out_vld_q;
  logic [WI-1:0] out_data_q;
  logic          fd_q;          // previous frame_done_in, for edge detect
  logic          done_q;

  logic          rd_en;
  logic          start_acc;
  logic          last_pix;
  logic          fd_rise;

  assign start_acc = start & (state_q == ST_IDLE);
  assign rd_en     = (state_q == ST_RUN) & ~hold;
  assign fd_rise   = frame_done_in & ~fd_q;

  raster_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (start_acc),
    .en_i   (rd_en),
    .addr_o (mem_addr),
    .last_o (last_pix)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start)            state_d = ST_RUN;
      ST_RUN:     if (rd_en & last_pix) state_d = ST_FLUSH;
      // Only the final read can be in flight here; leave once its block is out
      ST_FLUSH:   if (out_vld_q & ~rd_pend_q) state_d = ST_WAIT_WR;
      // A level already high on entry never produces fd_rise; a new edge is needed
      ST_WAIT_WR: if (fd_rise)          state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_NEAREST;
      rd_pend_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      fd_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_en;
      out_vld_q <= rd_pend_q;
      fd_q      <= frame_done_in;
      done_q    <= (state_q == ST_WAIT_WR) & fd_rise;
      if (start_acc) begin
        mode_q <= mode;
      end
      if (rd_pend_q) begin
        out_data_q <= WI'(pack_block(mode_q, mem_rdata));
      end
    end
  end

  assign mem_rd_en = rd_en;
  assign out_vld   = out_vld_q;
  assign out_data  = out_data_q;
  // done rises as the FSM lands in IDLE, so busy drops in the same cycle
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule : upsample_2x_ctrl
`default_nettype wire

// File: tb/tb_upsample_2x_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_upsample_2x_ctrl
//  Description : Self-checking bench for upsample_2x_ctrl on a 4x4 map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_upsample_2x_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start, mode, hold;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'h00;
  logic [31:0]   out_data;
  logic          out_vld;
  logic          frame_done_in;
  logic          busy, done;

  upsample_2x_ctrl #(
    .WI(32), .WIDTH(W), .HEIGHT(H), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_vld(out_vld), .frame_done_in(frame_done_in),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Source buffer: one-cycle read latency
  logic [7:0] mem [N];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Monitor, sampled on the falling edge
  logic [AW-1:0] addr_log[$];
  logic [31:0]   word_log[$];
  int            done_cnt = 0;
  logic          busy_at_done = 1'b1;
  logic          hold_chk = 1'b0;
  int            hold_viol = 0;

  always @(negedge clk) begin
    if (mem_rd_en) addr_log.push_back(mem_addr);
    if (out_vld)   word_log.push_back(out_data);
    if (done) begin
      done_cnt     = done_cnt + 1;
      busy_at_done = busy;
    end
    if (hold_chk && mem_rd_en) hold_viol = hold_viol + 1;
  end

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_w [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load_ramp(input logic m);
    logic [7:0] b;
    for (int k = 0; k < N; k++) begin
      b = 8'(k);
      mem[k] = b;
      exp_w[k] = (m == 1'b0) ? {b, b, b, b} : {24'h0, b};
    end
  endtask

  // Run one frame up to its last out_vld; optional hold after read hold_at
  // and a stray start pulse once start_at reads have been seen.
  task automatic do_frame(input logic m, input int hold_at, input int start_at, input string tag);
    int cyc, hold_left;
    bit held;
    addr_log.delete();
    word_log.delete();
    hold_viol = 0;
    @(posedge clk); #1; start = 1'b1; mode = m;
    @(posedge clk); #1; start = 1'b0; mode = ~m;   // must not affect this frame
    cyc = 0; held = 0; hold_left = 0;
    while (word_log.size() < N && cyc < 200) begin
      @(posedge clk); #1;
      cyc = cyc + 1;
      hold = 1'b0; hold_chk = 1'b0;
      if (hold_left > 0) begin
        hold = 1'b1; hold_chk = 1'b1; hold_left = hold_left - 1;
      end else if (hold_at >= 0 && !held && addr_log.size() == hold_at + 1) begin
        hold = 1'b1; hold_chk = 1'b1; held = 1; hold_left = 2;
      end
      start = (start_at >= 0 && addr_log.size() == start_at) ? 1'b1 : 1'b0;
    end
    hold = 1'b0; hold_chk = 1'b0; start = 1'b0;
    chk({tag, "_timeout"}, 32'(cyc < 200), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_hold_rd"}, 32'(hold_viol), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_nreads"}, 32'(addr_log.size()), 32'(N));
    chk({tag, "_nvld"}, 32'(word_log.size()), 32'(N));
    for (int k = 0; k < N && k < addr_log.size(); k++) begin
      if (addr_log[k] !== AW'(k)) begin
        chk({tag, "_addr_seq"}, 32'(addr_log[k]), 32'(k));
        break;
      end
    end
    for (int k = 0; k < N && k < word_log.size(); k++)
      chk($sformatf("%s_word%0d", tag, k), word_log[k], exp_w[k]);
    chk({tag, "_wait_vld"}, 32'(out_vld), 32'd0);
    chk({tag, "_wait_rd"}, 32'(mem_rd_en), 32'd0);
  endtask

  // Raise frame_done_in and expect a single done with busy already low
  task automatic finish_frame(input string tag);
    done_cnt = 0;
    busy_at_done = 1'b1;
    @(posedge clk); #1; frame_done_in = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    @(posedge clk); #1; frame_done_in = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        m;
    logic [7:0]  pix;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [5];

  initial begin
    int cyc, nv;

    vt[0] = '{1'b1, 8'hA5, 32'h000000A5};
    vt[1] = '{1'b0, 8'hA5, 32'hA5A5A5A5};
    vt[2] = '{1'b1, 8'hFF, 32'h000000FF};
    vt[3] = '{1'b0, 8'h3C, 32'h3C3C3C3C};
    vt[4] = '{1'b0, 8'h00, 32'h00000000};

    rstn = 1'b0; start = 1'b0; mode = 1'b0; hold = 1'b0; frame_done_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1; rstn = 1'b1;

    // Ramp, nearest replicate
    load_ramp(1'b0);
    do_frame(1'b0, -1, -1, "ramp_m0");
    finish_frame("ramp_m0");

    // Constant-pixel table
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < N; k++) begin
        mem[k] = vt[i].pix;
        exp_w[k] = vt[i].exp;
      end
      do_frame(vt[i].m, -1, -1, $sformatf("vec%0d", i));
      finish_frame($sformatf("vec%0d", i));
    end

    // Ramp, zero-insert
    load_ramp(1'b1);
    do_frame(1'b1, -1, -1, "ramp_m1");
    finish_frame("ramp_m1");

    // Hold for three cycles after read 5
    load_ramp(1'b0);
    do_frame(1'b0, 5, -1, "hold");
    finish_frame("hold");

    // Start pulse mid-frame is ignored
    do_frame(1'b0, -1, 3, "start_run");
    finish_frame("start_run");

    // Reset after 7 reads
    addr_log.delete();
    word_log.delete();
    @(posedge clk); #1; start = 1'b1; mode = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (addr_log.size() < 7 && cyc < 100) begin
      @(posedge clk); #1; cyc = cyc + 1;
    end
    chk("rst_mid_timeout", 32'(cyc < 100), 32'd1);
    rstn = 1'b0;
    nv = word_log.size();
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_no_vld", 32'(word_log.size()), 32'(nv));
    chk("rst_mid_busy", 32'(busy), 32'd0);
    do_frame(1'b0, -1, -1, "after_rst");
    finish_frame("after_rst");

    // frame_done_in already high at start
    @(posedge clk); #1; frame_done_in = 1'b1;
    repeat (2) @(posedge clk);
    done_cnt = 0;
    do_frame(1'b0, -1, -1, "fd_high");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fd_high_no_done", 32'(done_cnt), 32'd0);
    chk("fd_high_busy", 32'(busy), 32'd1);
    @(posedge clk); #1; frame_done_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fd_low_no_done", 32'(done_cnt), 32'd0);
    finish_frame("fd_high");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_upsample_2x_ctrl
`default_nettype wire
